fsk_bit_decoder: RTL

// Downstream consumer of frequency_analyzer. Sequences the analyzer's enable/clear per bit window,

---
 rtl/fsk_bit_decoder_if.sv | 25 ++
 rtl/fsk_bit_decoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fsk_bit_decoder_if.sv
// ----------------------------------------------------------------------------
// fsk_bit_decoder_if
// Byte stream from the FSK bit decoder to the capture/control logic.
//   data_out    8  assembled byte, LSB = first received bit
//   data_valid  1  byte available, held until accepted
//   data_ready  1  consumer accepts when data_valid & data_ready
// master = decoder side, slave = consumer side.
// ----------------------------------------------------------------------------
interface fsk_bit_decoder_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/fsk_bit_decoder.sv
// ----------------------------------------------------------------------------
// fsk_bit_decoder
// Sequences a frequency_analyzer over one bit window at a time, compares the
// two tone counts at window end, decides one FSK bit per window and packs the
// bits LSB-first into bytes delivered on a valid/ready handshake.
//
// Ports
//   clock            in   system clock, rising edge
//   reset            in   asynchronous, active-high reset
//   run              in   1 = decode continuously, 0 = stop at next boundary
//   analyzer_enable  out  analyzer count enable (high for WINDOW cycles)
//   analyzer_clear   out  analyzer clear (one cycle before each window)
//   f1_value         in   analyzer count for the logic-0 tone
//   f2_value         in   analyzer count for the logic-1 tone
//   bit_value        out  last decided bit, valid with bit_strobe
//   bit_strobe       out  one-cycle pulse per decided bit
//   bit_error        out  one-cycle pulse with bit_strobe on an ambiguous bit
//   overrun          out  sticky: byte completed while previous one pending
//   error_count      out  (FSK_DECODER_ERROR_CNT_EN only) saturating count
//                         of ambiguous bits
//   byte_if          master side of the byte stream interface
//
// Build option: define FSK_DECODER_ERROR_CNT_EN to add error_count and to
// drop ambiguous bits instead of shifting them in as 0.
// ----------------------------------------------------------------------------
module fsk_bit_decoder #(
    parameter int CLOCK         = 50000000,
    parameter int BIT_RATE      = 1000,
    parameter int MIN_COUNT     = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     run,
    output logic                     analyzer_enable,
    output logic                     analyzer_clear,
    input  logic [31:0]              f1_value,
    input  logic [31:0]              f2_value,
    output logic                     bit_value,
    output logic                     bit_strobe,
    output logic                     bit_error,
    output logic                     overrun,
`ifdef FSK_DECODER_ERROR_CNT_EN
    output logic [15:0]              error_count,
`endif
    fsk_bit_decoder_if.master        byte_if
);

    localparam int WINDOW = CLOCK / BIT_RATE;
    localparam int CNT_MAX = (WINDOW > SETTLE_CYCLES) ? WINDOW : SETTLE_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [31:0]      MIN_C       = 32'(MIN_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MEASURE,
        SETTLE,
        DECIDE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;
    logic             dec_bit;
    logic             dec_amb;
    logic             accept;

    // Returns {ambiguous, bit}. Unsigned compare; ties or weak winners are ambiguous.
    function automatic logic [1:0] decide_bit(input logic [31:0] f1, input logic [31:0] f2);
        if ((f2 > f1) && (f2 >= MIN_C))
            return 2'b01;
        else if ((f1 > f2) && (f1 >= MIN_C))
            return 2'b00;
        else
            return 2'b10;
    endfunction

`ifdef FSK_DECODER_ERROR_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    always_comb begin
        {dec_amb, dec_bit} = decide_bit(f1_value, f2_value);
`ifdef FSK_DECODER_ERROR_CNT_EN
        accept = ~dec_amb;
`else
        accept = 1'b1;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            bit_idx            <= '0;
            shift_q            <= '0;
            analyzer_enable    <= 1'b0;
            analyzer_clear     <= 1'b0;
            bit_value          <= 1'b0;
            bit_strobe         <= 1'b0;
            bit_error          <= 1'b0;
            overrun            <= 1'b0;
            byte_if.data_out   <= '0;
            byte_if.data_valid <= 1'b0;
`ifdef FSK_DECODER_ERROR_CNT_EN
            error_count        <= '0;
`endif
        end else begin
            bit_strobe <= 1'b0;
            bit_error  <= 1'b0;

            // Consumer handshake; a byte completing this same cycle overrides below.
            if (byte_if.data_valid && byte_if.data_ready)
                byte_if.data_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (run) begin
                        state          <= CLEAR;
                        analyzer_clear <= 1'b1;
                    end
                end

                CLEAR: begin
                    state           <= MEASURE;
                    analyzer_clear  <= 1'b0;
                    analyzer_enable <= 1'b1;
                    cnt             <= '0;
                end

                MEASURE: begin
                    if (cnt == WIN_LAST) begin
                        state           <= SETTLE;
                        analyzer_enable <= 1'b0;
                        cnt             <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SETTLE: begin
                    if (cnt == SETTLE_LAST)
                        state <= DECIDE;
                    else
                        cnt <= cnt + 1'b1;
                end

                DECIDE: begin
                    bit_strobe <= 1'b1;
                    bit_value  <= dec_bit;
                    bit_error  <= dec_amb;
`ifdef FSK_DECODER_ERROR_CNT_EN
                    if (dec_amb)
                        error_count <= sat_inc(error_count);
`endif
                    if (accept) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            byte_if.data_out   <= {dec_bit, shift_q[6:0]};
                            byte_if.data_valid <= 1'b1;
                            if (byte_if.data_valid && !byte_if.data_ready)
                                overrun <= 1'b1;
                            shift_q <= '0;
                        end else begin
                            shift_q[bit_idx] <= dec_bit;
                        end
                    end

                    if (run) begin
                        state          <= CLEAR;
                        analyzer_clear <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state           <= IDLE;
                    analyzer_enable <= 1'b0;
                    analyzer_clear  <= 1'b0;
                end
            endcase
        end
    end

endmodule
